// File: rtl/uart_bridge_pkg.sv
// Shared types and protocol constants for the UART register-access bridge.
package uart_bridge_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StGetAddr,
        StGetData,
        StRegWr,
        StRegRd,
        StRdCap,
        StSend,
        StWaitHi,
        StWaitLo
    } bridge_state_t;

    localparam logic [7:0] CMD_WR  = 8'h57;
    localparam logic [7:0] CMD_RD  = 8'h52;
    localparam logic [7:0] RSP_ACK = 8'h06;
    localparam logic [7:0] RSP_NAK = 8'h15;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/uart_cmd_bridge.sv
// Decodes 'W' addr data / 'R' addr commands from uart_rx, performs one local
// register access and answers with a single byte through uart_tx.
module uart_cmd_bridge
    import uart_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 43400
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    input  logic       parity_error,
    input  logic       framing_error,
    output logic       tx_start,
    output logic [7:0] tx_data,
    input  logic       tx_busy,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       bridge_busy,
    output logic [7:0] err_cnt
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    bridge_state_t    state_q;
    logic             is_wr_q;
    logic [CNT_W-1:0] tmo_cnt_q;
    logic             rx_good;
    logic             rx_bad;
    logic             rx_drop;

    assign rx_good = rx_done & ~parity_error & ~framing_error;
    assign rx_bad  = rx_done & (parity_error | framing_error);
    // Bytes landing while a transaction is executing or responding are discarded.
    assign rx_drop = rx_done & ~(state_q inside {StIdle, StGetAddr, StGetData});

    assign bridge_busy = (state_q != StIdle);
    // Decoded from the state register so the strobe lands in the SEND cycle itself.
    assign tx_start    = (state_q == StSend) & ~tx_busy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            is_wr_q   <= 1'b0;
            tmo_cnt_q <= '0;
            tx_data   <= '0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
            err_cnt   <= '0;
        end else begin
            reg_we <= 1'b0;
            reg_re <= 1'b0;
            if (rx_drop) begin
                err_cnt <= sat_inc(err_cnt);
            end

            unique case (state_q)
                StIdle: begin
                    if (rx_good && rx_data == CMD_WR) begin
                        is_wr_q   <= 1'b1;
                        tmo_cnt_q <= '0;
                        state_q   <= StGetAddr;
                    end else if (rx_good && rx_data == CMD_RD) begin
                        is_wr_q   <= 1'b0;
                        tmo_cnt_q <= '0;
                        state_q   <= StGetAddr;
                    end else if (rx_done) begin
                        tx_data <= RSP_NAK;
                        err_cnt <= sat_inc(err_cnt);
                        state_q <= StSend;
                    end
                end
                StGetAddr, StGetData: begin
                    if (rx_good) begin
                        tmo_cnt_q <= '0;
                        if (state_q == StGetAddr) begin
                            reg_addr <= rx_data;
                            if (is_wr_q) begin
                                state_q <= StGetData;
                            end else begin
                                reg_re  <= 1'b1;
                                state_q <= StRegRd;
                            end
                        end else begin
                            reg_wdata <= rx_data;
                            reg_we    <= 1'b1;
                            state_q   <= StRegWr;
                        end
                    end else if (rx_bad) begin
                        tmo_cnt_q <= '0;
                        tx_data   <= RSP_NAK;
                        err_cnt   <= sat_inc(err_cnt);
                        state_q   <= StSend;
                    end else if (tmo_cnt_q == TMO_LAST) begin
                        // Abandoned command: silently return to idle.
                        tmo_cnt_q <= '0;
                        err_cnt   <= sat_inc(err_cnt);
                        state_q   <= StIdle;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
                    end
                end
                StRegWr: begin
                    tx_data <= RSP_ACK;
                    state_q <= StSend;
                end
                StRegRd: begin
                    state_q <= StRdCap;
                end
                StRdCap: begin
                    tx_data <= reg_rdata;
                    state_q <= StSend;
                end
                StSend: begin
                    if (!tx_busy) begin
                        state_q <= StWaitHi;
                    end
                end
                StWaitHi: begin
                    if (tx_busy) begin
                        state_q <= StWaitLo;
                    end
                end
                StWaitLo: begin
                    if (!tx_busy) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_cmd_bridge.md
Name: uart_cmd_bridge

Overview:
- Register-access responder on the far end of the UART link.
- Consumes received bytes from uart_rx (rx_data/rx_done/parity_error/framing_error) and decodes a 2- or 3-byte command protocol.
- Performs single register reads and writes on a simple local bus.
- Returns a one-byte response through uart_tx (tx_start/tx_data/tx_busy).
- Instantiated beside uart_top in the device-side design.

Parameters:
- TIMEOUT_CYC, 43400, clk cycles allowed between bytes of one command (about 10 byte-times at 115200 baud / 50 MHz); minimum value 2.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- rx_data  in  8  received byte, valid while rx_done=1
- rx_done  in  1  one-cycle strobe per received byte
- parity_error  in  1  qualifies the current rx_done byte
- framing_error  in  1  qualifies the current rx_done byte
- tx_start  out  1  one-cycle request to uart_tx
- tx_data  out  8  response byte; held stable from tx_start until tx_busy falls
- tx_busy  in  1  uart_tx busy flag
- reg_addr  out  8  register address
- reg_wdata  out  8  write data
- reg_we  out  1  one-cycle write strobe
- reg_re  out  1  one-cycle read strobe
- reg_rdata  in  8  read data, valid exactly one cycle after reg_re
- bridge_busy  out  1  high in every state except IDLE
- err_cnt  out  8  saturating error counter

Behaviour:
- Reset state: all outputs 0; FSM in IDLE; timeout counter 0.
- Protocol, write: 0x57 ('W'), addr, data. Response is ACK 0x06.
- Protocol, read: 0x52 ('R'), addr. Response is the read data byte.
- Bad byte: any rx_done with parity_error or framing_error set counts as a bad byte.
- FSM states: IDLE, GET_ADDR, GET_DATA, REG_WR, REG_RD, RD_CAP, SEND, WAIT_HI, WAIT_LO.
- IDLE, on rx_done:
  - good 0x57: latch write flag, go to GET_ADDR.
  - good 0x52: latch read flag, go to GET_ADDR.
  - any other good byte, or a bad byte: tx_data=NAK 0x15, err_cnt++, go to SEND.
- GET_ADDR, on rx_done:
  - good byte: reg_addr<=rx_data; go to GET_DATA if write, else REG_RD.
  - bad byte: NAK, err_cnt++, go to SEND.
- GET_DATA, on rx_done:
  - good byte: reg_wdata<=rx_data, go to REG_WR.
  - bad byte: NAK, err_cnt++, go to SEND.
- REG_WR: reg_we=1 for exactly one cycle; tx_data<=0x06; go to SEND.
- REG_RD: reg_re=1 for exactly one cycle; go to RD_CAP.
- RD_CAP: tx_data<=reg_rdata; go to SEND.
- SEND:
  - If tx_busy=0: tx_start=1 for one cycle, go to WAIT_HI.
  - Otherwise stay in SEND with tx_start=0.
- WAIT_HI: wait for tx_busy=1, then go to WAIT_LO.
- WAIT_LO: wait for tx_busy=0, then go to IDLE.
- Response latency: the good last byte's rx_done leads to tx_start after 2 cycles for a write, 3 cycles for a read (tx_busy low).
- Inter-byte timeout:
  - Counter clears on every rx_done and on entry to GET_ADDR.
  - Counter increments each cycle in GET_ADDR/GET_DATA.
  - When it reaches TIMEOUT_CYC-1 with no rx_done that cycle: go to IDLE, err_cnt++, no response sent, no register access.
  - If rx_done coincides with the expiry cycle, the byte wins.
- Bytes arriving in REG_WR through WAIT_LO are dropped and err_cnt++; the current transaction is unaffected.
- err_cnt increments by at most 1 per cycle and saturates at 255 (no wrap).
- reg_addr and reg_wdata hold their last values between transactions.
- Reset asserted mid-operation: all outputs return to reset values immediately, no strobes are emitted, and the FSM restarts in IDLE.

Decomposition:
- Package uart_bridge_pkg holds:
  - state enum typedef bridge_state_t;
  - constants CMD_WR=8'h57, CMD_RD=8'h52, RSP_ACK=8'h06, RSP_NAK=8'h15.
- Single flat module; the timeout counter and error counter stay inline. No sub-module is warranted.

Test Plan:
- Write: bytes 0x57,0x12,0xA5 (clean) -> one reg_we pulse with reg_addr=0x12, reg_wdata=0xA5; then tx_start with tx_data=0x06; err_cnt stays 0.
- Read: bytes 0x52,0x34 with model returning 0x5C -> one reg_re pulse with reg_addr=0x34; then tx_data=0x5C; tx_start exactly 3 cycles after the second rx_done.
- Unknown command 0x41 -> tx_data=0x15, err_cnt=1, no reg strobes. Parity error on the address byte of a write -> NAK, err_cnt=2, no reg_we.
- Timeout: send 0x57, then nothing for TIMEOUT_CYC cycles -> back in IDLE, bridge_busy=0, err_cnt+1, no tx_start. A following 0x52,0x00 completes normally.
- Back-pressure and overrun: hold tx_busy=1 while a read completes -> tx_start withheld until tx_busy=0. A byte arriving during WAIT_LO -> dropped, err_cnt+1, the response still sent once.
- Reset mid-command (after 0x57,0x10) -> outputs 0, no reg_we. After release, 256 bad bytes -> err_cnt=255 (saturated).
